// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execution sequencer for the 16-bit ALU datapath (EXEC, MUL_WAIT, MEM, WB)
//   clk, resetn (async, active low)
//   instr_valid/instr_ready/instr : instruction handshake; ir holds the accepted word for the decoder
//   carry : CARRY flag owned here, updated in WB for ALU-class ops
//   mul_op, alu_result, alu_cout : decoder/ALU feedback captured during EXEC and MUL_WAIT
//   mem_req/mem_we/mem_addr/mem_ack/mem_rdata : load/store handshake for ldr/sti
//   rf_we/rf_waddr/rf_wdata : single-cycle register write-back
//   done/illegal : retire pulse and unrecognised-opcode flag
//   ALU_EXEC_CTRL_PERF_EN adds retired_cnt and stall_cnt
module alu_exec_ctrl #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [15:0]       ir,
   output logic              carry,
   input  logic              mul_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rf_we,
   output logic [1:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              done,
   output logic              illegal
`ifdef ALU_EXEC_CTRL_PERF_EN
   ,
   output logic [15:0]       retired_cnt,
   output logic [15:0]       stall_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, EXEC, MUL_WAIT, MEM, WB} state_t;
   state_t            state;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] result_q;
   logic              cout_q;
   logic [4:0]        op;
   logic              is_alu, is_ldr, is_sti, is_nop, illegal_op, mul_go, enter_wb;
   assign op         = ir[15:11];
   assign is_alu     = op >= 5'd1 && op <= 5'd12;
   assign is_ldr     = op == 5'b01110;
   assign is_sti     = op == 5'b11111;
   assign is_nop     = op == 5'd0;
   assign illegal_op = !(is_alu || is_ldr || is_sti || is_nop);
   assign mul_go     = mul_op && (MUL_CYCLES > 1);
   assign enter_wb   = (state == EXEC && !mul_go && !(is_ldr || is_sti)) ||
                       (state == MUL_WAIT && cnt == 4'd0) ||
                       (state == MEM && mem_ack);
   assign rf_waddr   = ir[10:9];
   assign rf_wdata   = result_q;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         ir          <= '0;
         carry       <= 1'b0;
         instr_ready <= 1'b1;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         rf_we       <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         cnt         <= '0;
      end else begin
         done    <= enter_wb;
         rf_we   <= enter_wb && (is_alu || is_ldr);
         illegal <= enter_wb && illegal_op;
         case (state)
            IDLE: if (instr_valid && instr_ready) begin
               ir          <= instr;
               instr_ready <= 1'b0;
               state       <= EXEC;
            end
            EXEC: begin
               result_q <= alu_result;
               cout_q   <= alu_cout;
               if (mul_go) begin
                  cnt   <= 4'(MUL_CYCLES - 2);
                  state <= MUL_WAIT;
               end else if (is_ldr || is_sti) begin
                  mem_addr <= alu_result;
                  mem_req  <= 1'b1;
                  mem_we   <= is_sti;
                  state    <= MEM;
               end else state <= WB;
            end
            MUL_WAIT: begin
               result_q <= alu_result;
               cout_q   <= alu_cout;
               cnt      <= cnt - 4'd1;
               if (cnt == 4'd0) state <= WB;
            end
            MEM: if (mem_ack) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               if (is_ldr) result_q <= mem_rdata;
               state   <= WB;
            end
            WB: begin
               if (is_alu) carry <= cout_q;
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef ALU_EXEC_CTRL_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         retired_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         retired_cnt <= retired_cnt + 16'(done);
         stall_cnt   <= stall_cnt + 16'(state == MUL_WAIT || (state == MEM && !mem_ack));
      end
   end
`endif
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed table, reset-abort sequence and randomized model check of alu_exec_ctrl
module tb_alu_exec_ctrl;
   localparam int DW = 16, MC = 4;
   logic clk = 1'b0, resetn = 1'b0, instr_valid = 1'b0, mul_op = 1'b0, alu_cout = 1'b0, mem_ack = 1'b0;
   logic [15:0] instr = '0, alu_result = '0, mem_rdata = '0;
   logic instr_ready, carry, mem_req, mem_we, rf_we, done, illegal;
   logic [15:0] ir, mem_addr, rf_wdata;
   logic [1:0] rf_waddr;
   int checks = 0, errors = 0;
   logic [15:0] hres [0:63];
   logic hco [0:63];
   typedef struct {
      logic [15:0] ins; int ackd; logic [15:0] rdata; int last; logic [15:0] res; logic co;
      int lat; logic we; logic [15:0] wd; logic ill; logic mwe; logic ca;
   } vec_t;
   vec_t tv [10];
   always #5 clk = ~clk;
   alu_exec_ctrl #(.DATA_W(DW), .MUL_CYCLES(MC)) dut (
      .clk(clk), .resetn(resetn), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .ir(ir), .carry(carry), .mul_op(mul_op), .alu_result(alu_result),
      .alu_cout(alu_cout), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .done(done), .illegal(illegal));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic run(input logic [15:0] ins, input int ackd, input logic [15:0] rdata,
                      input int flast, input logic [15:0] fres, input logic fco,
                      output int lat, output int nr, output logic [15:0] wd, output logic we,
                      output logic ill, output logic [15:0] maddr, output logic mwe, output logic ca);
      lat = 0; nr = 0; wd = 'x; we = 1'bx; ill = 1'bx; maddr = 'x; mwe = 1'bx;
      mul_op = ins[15:11] == 5'b00111;
      instr = ins;
      instr_valid = 1'b1;
      chk("ready_idle", instr_ready, 1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         chk("ready_busy", instr_ready, 0);
         chk("ir_hold", ir, ins);
         alu_result = (c == flast) ? fres : 16'($urandom);
         alu_cout = (c == flast) ? fco : 1'($urandom);
         hres[c] = alu_result;
         hco[c] = alu_cout;
         mem_ack = 1'b0;
         mem_rdata = 16'($urandom);
         if (mem_req) begin
            if (nr == 0) begin
               maddr = mem_addr;
               mwe = mem_we;
            end else begin
               chk("addr_stable", mem_addr, maddr);
               chk("we_stable", mem_we, mwe);
            end
            if (nr == ackd) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end
            nr++;
         end else mem_ack = 1'($urandom);
         if (done) begin
            lat = c;
            wd = rf_wdata;
            we = rf_we;
            ill = illegal;
            chk("waddr", rf_waddr, ins[10:9]);
         end else begin
            chk("we_no_done", rf_we, 0);
            chk("ill_no_done", illegal, 0);
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk("done_seen", lat != 0, 1);
      chk("ready_after", instr_ready, 1);
      chk("done_single", done, 0);
      chk("req_after", mem_req, 0);
      ca = carry;
   endtask
   logic [4:0] op;
   logic [15:0] ins, rd, wd, maddr;
   int ackd, k, last, elat, lat, nr;
   logic alu, ldr, sti, mul, nopr, mcarry, we, ill, mwe, ca, memop;
   initial begin
      tv[0] = '{16'h0800, 0, 16'h0000, 1, 16'h1234, 1'b1, 2, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1};
      tv[1] = '{16'h7400, 3, 16'hBEEF, 1, 16'h0040, 1'b0, 6, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1};
      tv[2] = '{16'hF800, 0, 16'h1111, 1, 16'h0ABC, 1'b0, 3, 1'b0, 16'h0ABC, 1'b0, 1'b1, 1'b1};
      tv[3] = '{16'h8000, 0, 16'h0000, 1, 16'h5555, 1'b0, 2, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b1};
      tv[4] = '{16'h3A00, 0, 16'h0000, 4, 16'h00F0, 1'b0, 5, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0};
      tv[5] = '{16'h0E00, 0, 16'h0000, 1, 16'hFFFF, 1'b1, 2, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1};
      tv[6] = '{16'h0000, 0, 16'h0000, 1, 16'h0001, 1'b0, 2, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
      tv[7] = '{16'h6800, 0, 16'h0000, 1, 16'h2222, 1'b0, 2, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b1};
      tv[8] = '{16'h6000, 0, 16'h0000, 1, 16'h3333, 1'b0, 2, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0};
      tv[9] = '{16'h7200, 0, 16'hCAFE, 1, 16'h0080, 1'b1, 3, 1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_done", done, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_ir", ir, 0);
      chk("rst_carry", carry, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", rf_wdata, 0);
      resetn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         run(tv[i].ins, tv[i].ackd, tv[i].rdata, tv[i].last, tv[i].res, tv[i].co,
             lat, nr, wd, we, ill, maddr, mwe, ca);
         memop = tv[i].ins[15:11] == 5'b01110 || tv[i].ins[15:11] == 5'b11111;
         chk("tbl_lat", lat, tv[i].lat);
         chk("tbl_rf_we", we, tv[i].we);
         chk("tbl_wdata", wd, tv[i].wd);
         chk("tbl_illegal", ill, tv[i].ill);
         chk("tbl_carry", ca, tv[i].ca);
         chk("tbl_nreq", nr, memop ? tv[i].ackd + 1 : 0);
         if (memop) begin
            chk("tbl_addr", maddr, tv[i].res);
            chk("tbl_mem_we", mwe, tv[i].mwe);
         end
      end
      instr = 16'h7000;
      mul_op = 1'b0;
      alu_result = 16'h0100;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_req_up", mem_req, 1);
      #2 resetn = 1'b0;
      #1;
      chk("abort_req_drop", mem_req, 0);
      chk("abort_ready", instr_ready, 1);
      chk("abort_carry", carry, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_done", done, 0);
         chk("abort_no_we", rf_we, 0);
         chk("abort_idle", instr_ready, 1);
         chk("abort_no_req", mem_req, 0);
         @(posedge clk); #1;
      end
      mcarry = 1'b0;
      for (int n = 0; n < 200; n++) begin
         k = $urandom_range(0, 5);
         op = k == 0 ? 5'd7 : k == 1 ? 5'd14 : k == 2 ? 5'd31 : 5'($urandom);
         ins = {op, 11'($urandom)};
         ackd = $urandom_range(0, 4);
         rd = 16'($urandom);
         run(ins, ackd, rd, 0, 16'h0, 1'b0, lat, nr, wd, we, ill, maddr, mwe, ca);
         alu = op >= 5'd1 && op <= 5'd12;
         ldr = op == 5'd14;
         sti = op == 5'd31;
         mul = op == 5'd7;
         nopr = op == 5'd0;
         last = mul ? MC : 1;
         elat = (ldr || sti) ? 3 + ackd : mul ? MC + 1 : 2;
         if (alu) mcarry = hco[last];
         chk("rnd_lat", lat, elat);
         chk("rnd_rf_we", we, alu || ldr);
         chk("rnd_wdata", wd, ldr ? rd : hres[last]);
         chk("rnd_illegal", ill, !(alu || ldr || sti || nopr));
         chk("rnd_carry", ca, mcarry);
         chk("rnd_nreq", nr, (ldr || sti) ? ackd + 1 : 0);
         if (ldr || sti) begin
            chk("rnd_addr", maddr, hres[1]);
            chk("rnd_mem_we", mwe, sti);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
